// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial LSB-first subtractor for the TinyTapeout user slot; borrow carried across strobes.
// Define SERSUB_ADD_EN to add a per-operation add/subtract mode selected by ui_in[3].
module tt_um_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_sreg, w_sreg_n;
    logic [WIDTH-1:0] r_result, w_result_n;
    logic [CW-1:0]    r_cnt, w_cnt_n;
    logic             r_bw, w_bw_n;
    logic             r_flag, w_flag_n;
    logic             r_pulse, w_pulse_n;

    logic w_a, w_b, w_valid, w_clr;
    logic w_first, w_bw_in, w_d, w_bw_next;
    logic [WIDTH-1:0] w_shifted;

    assign w_a     = ui_in[0];
    assign w_b     = ui_in[1];
    assign w_valid = ui_in[2];
    assign w_clr   = ui_in[4];

    // A bit accepted outside SHIFT starts a new operation with no incoming borrow.
    assign w_first = (r_state != SHIFT);
    assign w_bw_in = w_first ? 1'b0 : r_bw;
    assign w_d     = w_a ^ w_b ^ w_bw_in;

`ifdef SERSUB_ADD_EN
    logic r_mode, w_mode_n, w_mode;
    assign w_mode    = w_first ? ui_in[3] : r_mode;
    assign w_bw_next = w_mode ? ((w_a & w_b) | ((w_a ^ w_b) & w_bw_in))
                              : ((~w_a & w_b) | (~(w_a ^ w_b) & w_bw_in));
`else
    assign w_bw_next = (~w_a & w_b) | (~(w_a ^ w_b) & w_bw_in);
`endif

    assign w_shifted = {w_d, r_sreg[WIDTH-1:1]};

    always_comb begin
        w_state_n  = r_state;
        w_sreg_n   = r_sreg;
        w_result_n = r_result;
        w_cnt_n    = r_cnt;
        w_bw_n     = r_bw;
        w_flag_n   = r_flag;
        w_pulse_n  = 1'b0;
`ifdef SERSUB_ADD_EN
        w_mode_n   = r_mode;
`endif
        if (w_clr) begin
            w_state_n = IDLE;
            w_sreg_n  = '0;
            w_bw_n    = 1'b0;
            w_cnt_n   = '0;
        end else if (w_valid) begin
            w_sreg_n = w_shifted;
            w_bw_n   = w_bw_next;
            if (w_first) begin
                w_state_n = SHIFT;
                w_cnt_n   = CW'(1);
`ifdef SERSUB_ADD_EN
                w_mode_n  = ui_in[3];
`endif
            end else if (r_cnt == LAST) begin
                w_state_n  = HOLD;
                w_cnt_n    = '0;
                w_result_n = w_shifted;
                w_flag_n   = w_bw_next;
                w_pulse_n  = 1'b1;
            end else begin
                w_cnt_n = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sreg   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_bw     <= 1'b0;
            r_flag   <= 1'b0;
            r_pulse  <= 1'b0;
`ifdef SERSUB_ADD_EN
            r_mode   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_n;
            r_sreg   <= w_sreg_n;
            r_result <= w_result_n;
            r_cnt    <= w_cnt_n;
            r_bw     <= w_bw_n;
            r_flag   <= w_flag_n;
            r_pulse  <= w_pulse_n;
`ifdef SERSUB_ADD_EN
            r_mode   <= w_mode_n;
`endif
        end
    end

    assign uo_out  = 8'(r_result);
    assign uio_out = {4'b0000, r_pulse, (r_state == SHIFT), r_flag, (r_state == HOLD)};
    assign uio_oe  = 8'b0000_1111;

    logic w_unused;
    assign w_unused = &{1'b0, ena, uio_in, ui_in[7:5], ui_in[3]};

endmodule
